// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared flag-vector layout and pending-writer state encoding.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int FLAG_W = 5;
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Q = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        FULL = 2'd2
    } flag_state_t;

endpackage
`default_nettype wire

// File: rtl/flag_pend_ctr.sv
`default_nettype none
// ============================================================================
// Module   : flag_pend_ctr
// Brief    : Counts outstanding multi-cycle flag writers; drives MulStallE.
// Revision : 1.0
// ============================================================================
module flag_pend_ctr
    import cpu_pkg::*;
#(
    parameter int MAX_PEND = 2,
    parameter int CNT_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_req,
    input  logic        done_valid,
    output flag_state_t state,
    output flag_state_t state_next,
    output logic        mul_stall,
    output logic        busy
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_PEND);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    flag_state_t      r_state;
    flag_state_t      w_state_next;
    logic             w_inc;
    logic             w_dec;

    // A retire frees a slot in the same cycle, so FULL only blocks without one.
    assign mul_stall = (r_state == FULL) & ~done_valid;
    assign w_inc     = inc_req & ~mul_stall;
    assign w_dec     = done_valid & (r_cnt != '0);
    assign busy      = (r_cnt != '0);

    always_comb begin
        w_cnt_next   = r_cnt;
        w_state_next = r_state;
        if (w_inc && !w_dec) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end else if (w_dec && !w_inc) begin
            w_cnt_next = r_cnt - CNT_W'(1);
        end
        if (w_cnt_next == '0) begin
            w_state_next = IDLE;
        end else if (w_cnt_next == C_MAX) begin
            w_state_next = FULL;
        end else begin
            w_state_next = PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_state <= IDLE;
        end else begin
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
        end
    end

    assign state      = r_state;
    assign state_next = w_state_next;

endmodule
`default_nettype wire

// File: rtl/flag_reg_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_reg_unit
// Brief    : Execute-stage NZCVQ register with multi-cycle writer hazard stall.
//            FLAG_FWD_EN: forward retiring multiply flags, drop stall early.
// Revision : 1.0
// ============================================================================
module flag_reg_unit
    import cpu_pkg::*;
#(
    parameter int MAX_PEND = 2,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic [FLAG_W-1:0] FlagsNextE,
    input  logic              FlagsWriteE,
    input  logic              QSetE,
    input  logic              MsrWriteE,
    input  logic [FLAG_W-1:0] MsrDataE,
    input  logic              MulStartE,
    input  logic              MulDoneValid,
    input  logic [3:0]        MulDoneFlags,
    input  logic              FlagReadD,
    input  logic              FlagWriteD,
    output logic [FLAG_W-1:0] Flags,
    output logic              FlagStallD,
    output logic              MulStallE,
    output logic              FlagsBusy
);

    logic        w_eok;
    logic        w_msr;
    logic        w_fwr;
    logic [3:0]  r_nzcv;
    logic        r_q;
    logic [3:0]  w_nzcv_next;
    logic        w_q_next;
    flag_state_t w_state;
    flag_state_t w_state_next;
    logic        w_unused;

    assign w_eok = ~StallE & ~FlushE;
    assign w_msr = MsrWriteE & w_eok;
    assign w_fwr = FlagsWriteE & w_eok;

    always_comb begin
        w_nzcv_next = r_nzcv;
        w_q_next    = r_q;
        if (w_msr) begin
            w_nzcv_next = MsrDataE[FLAG_N:FLAG_V];
            w_q_next    = MsrDataE[FLAG_Q];
        end else begin
            if (w_fwr) begin
                w_nzcv_next = FlagsNextE[FLAG_N:FLAG_V];
            end else if (MulDoneValid) begin
                w_nzcv_next = MulDoneFlags;
            end
            // Q is sticky: only MSR or reset can clear it.
            if (QSetE && w_eok) begin
                w_q_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nzcv <= '0;
            r_q    <= 1'b0;
        end else begin
            r_nzcv <= w_nzcv_next;
            r_q    <= w_q_next;
        end
    end

    flag_pend_ctr #(
        .MAX_PEND (MAX_PEND),
        .CNT_W    (CNT_W)
    ) u_pend (
        .clk        (clk),
        .reset      (reset),
        .inc_req    (MulStartE & w_eok),
        .done_valid (MulDoneValid),
        .state      (w_state),
        .state_next (w_state_next),
        .mul_stall  (MulStallE),
        .busy       (FlagsBusy)
    );

`ifdef FLAG_FWD_EN
    assign Flags      = {(MulDoneValid && !w_msr && !w_fwr) ? MulDoneFlags : r_nzcv, r_q};
    // Release decode in the retire cycle that empties the counter.
    assign FlagStallD = (w_state != IDLE) & (w_state_next != IDLE) & (FlagReadD | FlagWriteD);
    assign w_unused   = FlagsNextE[FLAG_Q];
`else
    assign Flags      = {r_nzcv, r_q};
    assign FlagStallD = (w_state != IDLE) & (FlagReadD | FlagWriteD);
    assign w_unused   = FlagsNextE[FLAG_Q] ^ (^w_state_next);
`endif

endmodule
`default_nettype wire

// File: tb/tb_flag_reg_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_reg_unit
// Brief    : Directed plus random stimulus against a behavioural flag model.
// Revision : 1.0
// ============================================================================
module tb_flag_reg_unit;
    import cpu_pkg::*;

    localparam int MAX_PEND = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              StallE, FlushE, FlagsWriteE, QSetE, MsrWriteE;
    logic              MulStartE, MulDoneValid, FlagReadD, FlagWriteD;
    logic [FLAG_W-1:0] FlagsNextE, MsrDataE;
    logic [3:0]        MulDoneFlags;
    logic [FLAG_W-1:0] Flags;
    logic              FlagStallD, MulStallE, FlagsBusy;

    flag_reg_unit #(.MAX_PEND(MAX_PEND), .CNT_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .FlagsNextE   (FlagsNextE),
        .FlagsWriteE  (FlagsWriteE),
        .QSetE        (QSetE),
        .MsrWriteE    (MsrWriteE),
        .MsrDataE     (MsrDataE),
        .MulStartE    (MulStartE),
        .MulDoneValid (MulDoneValid),
        .MulDoneFlags (MulDoneFlags),
        .FlagReadD    (FlagReadD),
        .FlagWriteD   (FlagWriteD),
        .Flags        (Flags),
        .FlagStallD   (FlagStallD),
        .MulStallE    (MulStallE),
        .FlagsBusy    (FlagsBusy)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] m_nzcv;
    logic       m_q;
    int         m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; StallE = 1'b0; FlushE = 1'b0; FlagsWriteE = 1'b0; QSetE = 1'b0;
        MsrWriteE = 1'b0; MulStartE = 1'b0; MulDoneValid = 1'b0; FlagReadD = 1'b0;
        FlagWriteD = 1'b0; FlagsNextE = '0; MsrDataE = '0; MulDoneFlags = '0;
    endtask

    // Compare outputs with the model for the current inputs, then clock once.
    task automatic step();
        logic       eok, full_blk, inc, dec, exp_stall;
        logic [4:0] exp_flags;
        #1;
        eok       = !StallE && !FlushE;
        full_blk  = (m_pend == MAX_PEND) && !MulDoneValid;
        inc       = MulStartE && eok && !full_blk;
        dec       = MulDoneValid && (m_pend > 0);
        exp_flags = {m_nzcv, m_q};
`ifdef FLAG_FWD_EN
        if (MulDoneValid && !(eok && (MsrWriteE || FlagsWriteE))) exp_flags[4:1] = MulDoneFlags;
        exp_stall = (m_pend > 0) && !(m_pend == 1 && dec && !inc) && (FlagReadD || FlagWriteD);
`else
        exp_stall = (m_pend > 0) && (FlagReadD || FlagWriteD);
`endif
        check("flags",    32'(Flags),      32'(exp_flags));
        check("stall_d",  32'(FlagStallD), 32'(exp_stall));
        check("mulstall", 32'(MulStallE),  32'(full_blk));
        check("busy",     32'(FlagsBusy),  32'(m_pend != 0));
        @(posedge clk);
        if (reset) begin
            m_nzcv = '0; m_q = 1'b0; m_pend = 0;
        end else begin
            if (eok && MsrWriteE) begin
                m_nzcv = MsrDataE[4:1];
                m_q    = MsrDataE[0];
            end else begin
                if (eok && FlagsWriteE) m_nzcv = FlagsNextE[4:1];
                else if (MulDoneValid)  m_nzcv = MulDoneFlags;
                if (eok && QSetE) m_q = 1'b1;
            end
            m_pend = m_pend + int'(inc) - int'(dec);
        end
        @(negedge clk);
    endtask

    initial begin
        m_nzcv = '0; m_q = 1'b0; m_pend = 0;
        idle();
        reset = 1'b1;
        @(negedge clk);
        step();
        step();
        idle(); #1;
        check("rst_flags", 32'(Flags), 32'h0);
        check("rst_busy",  32'(FlagsBusy), 32'h0);
        check("rst_mulst", 32'(MulStallE), 32'h0);

        FlagsWriteE = 1'b1; FlagsNextE = 5'b01100; step();
        idle(); #1; check("wr_flags", 32'(Flags), 32'h0C);
        FlagsWriteE = 1'b1; FlagsNextE = 5'b10011; StallE = 1'b1; step();
        StallE = 1'b0; FlushE = 1'b1; step();
        idle(); #1; check("wr_blocked", 32'(Flags), 32'h0C);
        QSetE = 1'b1; step();
        idle(); #1; check("qset", 32'(Flags), 32'h0D);
        FlagsWriteE = 1'b1; FlagsNextE = 5'b00000; step();
        idle(); #1; check("q_sticky", 32'(Flags), 32'h01);
        MsrWriteE = 1'b1; MsrDataE = 5'b10000; step();
        idle(); #1; check("msr", 32'(Flags), 32'h10);

        MulStartE = 1'b1; step();
        idle(); FlagReadD = 1'b1; step();
        #1; check("raw_stall", 32'(FlagStallD), 32'h1);
        MulDoneValid = 1'b1; MulDoneFlags = 4'b0110; #1;
`ifdef FLAG_FWD_EN
        check("retire_stall", 32'(FlagStallD), 32'h0);
`else
        check("retire_stall", 32'(FlagStallD), 32'h1);
`endif
        step();
        MulDoneValid = 1'b0; #1;
        check("post_stall", 32'(FlagStallD), 32'h0);
        check("mul_flags",  32'(Flags), 32'h0C);

        idle(); MulStartE = 1'b1; step(); step();
        #1; check("full_mulst", 32'(MulStallE), 32'h1);
        step();
        MulStartE = 1'b0; MulDoneValid = 1'b1; MulDoneFlags = 4'b1010;
        FlagsWriteE = 1'b1; FlagsNextE = 5'b01010; #1;
        check("done_mulst", 32'(MulStallE), 32'h0);
        step();
        idle(); #1;
        check("e_wins", 32'(Flags), 32'h0A);
        check("cnt_one", 32'(FlagsBusy), 32'h1);
        MulStartE = 1'b1; step();
        idle(); reset = 1'b1; step();
        idle(); FlagReadD = 1'b1; #1;
        check("rst_busy2",  32'(FlagsBusy), 32'h0);
        check("rst_stall2", 32'(FlagStallD), 32'h0);
        MulDoneValid = 1'b1; MulDoneFlags = 4'b1111; step();
        idle(); #1;
        check("late_done", 32'(Flags), 32'h1E);

        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            StallE       = ($urandom_range(0, 5) == 0);
            FlushE       = ($urandom_range(0, 7) == 0);
            FlagsWriteE  = ($urandom_range(0, 3) == 0);
            FlagsNextE   = 5'($urandom);
            QSetE        = ($urandom_range(0, 9) == 0);
            MsrWriteE    = ($urandom_range(0, 15) == 0);
            MsrDataE     = 5'($urandom);
            MulStartE    = ($urandom_range(0, 2) == 0);
            MulDoneValid = (m_pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            MulDoneFlags = 4'($urandom);
            FlagReadD    = 1'($urandom);
            FlagWriteD   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flag_reg_unit.md
Name: flag_reg_unit

Overview:
- Execute-stage status-flag register: holds architectural NZCVQ and feeds it to the condition evaluator every cycle.
- Captures the evaluator's next-flags result and MSR writes.
- Keeps Q sticky.
- Tracks outstanding multi-cycle flag-setting multiplies and stalls decode on flag hazards until they retire.

Parameters:
- FLAG_W, 5: flag vector width; bit 4 N, 3 Z, 2 C, 1 V, 0 Q.
- MAX_PEND, 2: maximum outstanding multi-cycle flag writers.
- CNT_W, 2: pending-counter width; must satisfy 2^CNT_W > MAX_PEND.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- StallE  in  1  execute stage held
- FlushE  in  1  execute-stage instruction cancelled
- FlagsNextE  in  FLAG_W  next flags from condition evaluator; bits [4:1] used
- FlagsWriteE  in  1  E-stage instruction writes NZCV (already condition-qualified)
- QSetE  in  1  E-stage saturating op saturated
- MsrWriteE  in  1  E-stage MSR to flags
- MsrDataE  in  FLAG_W  MSR value
- MulStartE  in  1  E-stage launches multi-cycle flag-setting multiply
- MulDoneValid  in  1  oldest pending multiply retires this cycle
- MulDoneFlags  in  4  its NZCV
- FlagReadD  in  1  decode instruction is conditional or reads C
- FlagWriteD  in  1  decode instruction writes flags
- Flags  out  FLAG_W  current flags to condition evaluator
- FlagStallD  out  1  stall fetch/decode
- MulStallE  out  1  E-stage multiply must not launch (counter full)
- FlagsBusy  out  1  pend_cnt != 0

Behaviour:
- Reset (synchronous, clk edge with reset=1): flag register = 0, pend_cnt = 0, state IDLE.
  - Outputs then: Flags = 0, FlagStallD = 0, MulStallE = 0, FlagsBusy = 0.
- E-stage qualifier: e_ok = ~StallE & ~FlushE. All E-stage writes require e_ok. MulDoneValid is not qualified by StallE or FlushE.
- NZCV update priority, highest first:
  1. MsrWriteE & e_ok: load MsrDataE[4:1].
  2. FlagsWriteE & e_ok: load FlagsNextE[4:1].
  3. MulDoneValid: load MulDoneFlags.
  4. Otherwise hold.
- Q update:
  - MsrWriteE & e_ok: Q = MsrDataE[0].
  - Else QSetE & e_ok: Q = 1.
  - Else hold. Q is never cleared except by MSR or reset.
- Pending counter:
  - inc = MulStartE & e_ok & ~MulStallE.
  - dec = MulDoneValid & (pend_cnt != 0).
  - pend_cnt += inc - dec; simultaneous inc and dec leaves it unchanged.
  - MulDoneValid with pend_cnt == 0 is ignored for the counter; the flag update still occurs.
  - Saturates at MAX_PEND.
- States:
  - IDLE (cnt = 0): inc -> PEND.
  - PEND (cnt > 0): next cnt = 0 -> IDLE.
  - FULL (cnt = MAX_PEND): dec without inc -> PEND.
- MulStallE = (state == FULL) & ~MulDoneValid. Combinational.
- FlagStallD = (state != IDLE) & (FlagReadD | FlagWriteD).
  - Covers RAW on pending flags.
  - Covers WAW: prevents a younger write from being overwritten by a late multiply result.
- Flags is the register output; combinational paths only under the optional feature.
- FlushE with a pending multiply does not cancel it. The multiply was issued older and still retires.
- Reset mid-operation: discards pending count; MulDoneValid arriving afterwards updates NZCV only.

Optional Feature:
- Macro: FLAG_FWD_EN.
- Defined:
  - Flags[4:1] = MulDoneFlags when MulDoneValid and no higher-priority E write; otherwise the register.
  - FlagStallD deasserts in the same cycle that MulDoneValid drops the counter from 1 to 0.
- Undefined:
  - Flags is purely registered.
  - FlagStallD remains high through the retire cycle and drops the cycle after (one extra bubble).

Decomposition:
- Shared package (cpu_pkg): FLAG_W, bit-index constants FLAG_N/Z/C/V/Q, and the state enum IDLE/PEND/FULL.
- One natural sub-module: flag_pend_ctr, holding the pending counter, state and MulStallE.
- Register and priority mux stay in the top module.

Test Plan:
- Reset, then FlagsWriteE=1 with FlagsNextE=5'b01100 -> next cycle Flags=5'b01100.
- Repeat the same write with StallE=1 or FlushE=1 -> Flags unchanged.
- QSetE=1 -> Q=1.
- FlagsWriteE with FlagsNextE=0 -> Q stays 1.
- MsrWriteE with MsrDataE=5'b10000 -> Flags=5'b10000 (Q cleared).
- MulStartE, then FlagReadD=1 held:
  - FlagStallD=1 until MulDoneValid with MulDoneFlags=4'b0110.
  - Flags=5'b0110q after.
  - Stall drop: same cycle with FLAG_FWD_EN, next cycle without.
- Two MulStartE back-to-back -> FULL, MulStallE=1.
- Third MulStartE is not counted.
- MulDoneValid -> MulStallE=0 that cycle; pend_cnt 2->1.
- MulDoneValid and FlagsWriteE (e_ok) same cycle with differing values -> FlagsNextE value wins.
- Reset while pend_cnt=2 -> pend_cnt=0, FlagsBusy=0, FlagStallD=0 next cycle.
